// File: rtl/cbus_arbiter.sv
// cbus_arbiter: two-port (instruction/data) arbiter onto a single bus converter request channel,
// data-priority with an instruction anti-starvation limit and one idle cycle between grants.
module cbus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req_valid,
    input  logic        i_req_is_write,
    input  logic [2:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [3:0]  i_req_strobe,
    input  logic [31:0] i_req_data,
    input  logic [3:0]  i_req_len,
    input  logic        d_req_valid,
    input  logic        d_req_is_write,
    input  logic [2:0]  d_req_size,
    input  logic [31:0] d_req_addr,
    input  logic [3:0]  d_req_strobe,
    input  logic [31:0] d_req_data,
    input  logic [3:0]  d_req_len,
    output logic        i_resp_ready,
    output logic        i_resp_last,
    output logic [31:0] i_resp_data,
    output logic        d_resp_ready,
    output logic        d_resp_last,
    output logic [31:0] d_resp_data,
    output logic        oreq_valid,
    output logic        oreq_is_write,
    output logic [2:0]  oreq_size,
    output logic [31:0] oreq_addr,
    output logic [3:0]  oreq_strobe,
    output logic [31:0] oreq_data,
    output logic [3:0]  oreq_len,
    input  logic        oresp_ready,
    input  logic        oresp_last,
    input  logic [31:0] oresp_data
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          sel_i, sel_d, starved;

    assign sel_i   = state == BUSY_I;
    assign sel_d   = state == BUSY_D;
    assign starved = starve_cnt == CW'(STARVE_LIMIT);

    // A D grant with an instruction waiting is only possible below the limit, so the increment saturates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (d_req_valid && !(i_req_valid && starved)) begin
                state <= BUSY_D;
                if (i_req_valid) starve_cnt <= starve_cnt + CW'(1);
            end else if (i_req_valid) begin
                state      <= BUSY_I;
                starve_cnt <= '0;
            end
        end else if (oresp_ready && oresp_last) begin
            state <= IDLE;
        end
    end

    always_comb begin
        oreq_valid    = sel_i ? i_req_valid    : sel_d ? d_req_valid    : 1'b0;
        oreq_is_write = sel_i ? i_req_is_write : sel_d ? d_req_is_write : 1'b0;
        oreq_size     = sel_i ? i_req_size     : sel_d ? d_req_size     : 3'd0;
        oreq_addr     = sel_i ? i_req_addr     : sel_d ? d_req_addr     : 32'd0;
        oreq_strobe   = sel_i ? i_req_strobe   : sel_d ? d_req_strobe   : 4'd0;
        oreq_data     = sel_i ? i_req_data     : sel_d ? d_req_data     : 32'd0;
        oreq_len      = sel_i ? i_req_len      : sel_d ? d_req_len      : 4'd0;
        i_resp_ready  = sel_i & oresp_ready;
        i_resp_last   = sel_i & oresp_last;
        d_resp_ready  = sel_d & oresp_ready;
        d_resp_last   = sel_d & oresp_last;
        i_resp_data   = oresp_data;
        d_resp_data   = oresp_data;
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of grants, starvation count and pass-through outputs.
module tb_cbus_arbiter;
    localparam int L = 4;
    localparam logic [31:0] IA = 32'h0000_1000, DA = 32'h0000_2000;

    logic clk = 0, resetn;
    logic i_req_valid, i_req_is_write, d_req_valid, d_req_is_write;
    logic [2:0] i_req_size, d_req_size;
    logic [31:0] i_req_addr, i_req_data, d_req_addr, d_req_data;
    logic [3:0] i_req_strobe, i_req_len, d_req_strobe, d_req_len;
    logic i_resp_ready, i_resp_last, d_resp_ready, d_resp_last;
    logic [31:0] i_resp_data, d_resp_data;
    logic oreq_valid, oreq_is_write;
    logic [2:0] oreq_size;
    logic [31:0] oreq_addr, oreq_data;
    logic [3:0] oreq_strobe, oreq_len;
    logic oresp_ready, oresp_last;
    logic [31:0] oresp_data;

    int total = 0, bad = 0;
    int owner = 0;  // 0: nobody holds the bus, 1: instruction, 2: data
    int waits = 0;  // data grants taken while an instruction request was waiting

    cbus_arbiter #(.STARVE_LIMIT(L)) dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(i_req_valid), .i_req_is_write(i_req_is_write), .i_req_size(i_req_size),
        .i_req_addr(i_req_addr), .i_req_strobe(i_req_strobe), .i_req_data(i_req_data), .i_req_len(i_req_len),
        .d_req_valid(d_req_valid), .d_req_is_write(d_req_is_write), .d_req_size(d_req_size),
        .d_req_addr(d_req_addr), .d_req_strobe(d_req_strobe), .d_req_data(d_req_data), .d_req_len(d_req_len),
        .i_resp_ready(i_resp_ready), .i_resp_last(i_resp_last), .i_resp_data(i_resp_data),
        .d_resp_ready(d_resp_ready), .d_resp_last(d_resp_last), .d_resp_data(d_resp_data),
        .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_size(oreq_size),
        .oreq_addr(oreq_addr), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data), .oreq_len(oreq_len),
        .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [76:0] i_bundle();
        return {i_req_valid, i_req_is_write, i_req_size, i_req_addr, i_req_strobe, i_req_data, i_req_len};
    endfunction

    function automatic logic [76:0] d_bundle();
        return {d_req_valid, d_req_is_write, d_req_size, d_req_addr, d_req_strobe, d_req_data, d_req_len};
    endfunction

    function automatic logic [76:0] exp_oreq();
        return owner == 1 ? i_bundle() : owner == 2 ? d_bundle() : 77'd0;
    endfunction

    function automatic logic [3:0] exp_resp();
        return owner == 1 ? {oresp_ready, oresp_last, 2'b00} :
               owner == 2 ? {2'b00, oresp_ready, oresp_last} : 4'b0000;
    endfunction

    // Transaction-level view: who gets the bus next, and how long the instruction side has waited.
    task automatic advance();
        @(posedge clk);
        if (resetn) begin
            if (owner == 0) begin
                if (i_req_valid && (!d_req_valid || waits >= L)) begin
                    owner = 1;
                    waits = 0;
                end else if (d_req_valid) begin
                    owner = 2;
                    if (i_req_valid) waits = waits + 1;
                end
            end else if (oresp_ready && oresp_last) owner = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {i_req_valid, i_req_is_write, i_req_size, i_req_addr, i_req_strobe, i_req_data, i_req_len} = '0;
        {d_req_valid, d_req_is_write, d_req_size, d_req_addr, d_req_strobe, d_req_data, d_req_len} = '0;
        {oresp_ready, oresp_last} = 2'b00;
        oresp_data = 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        {i_req_valid, d_req_valid, oresp_ready, oresp_last} = 4'hF;
        resetn = 0;
        owner = 0;
        waits = 0;
        #1;
        total++;
        if ({oreq_valid, oreq_addr, i_resp_ready, i_resp_last, d_resp_ready, d_resp_last} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b addr=%h rdy=%b%b last=%b%b want all 0",
                     oreq_valid, oreq_addr, i_resp_ready, d_resp_ready, i_resp_last, d_resp_last);
        end
        advance();
        advance();
        total++;
        if (dut.starve_cnt !== 3'd0 || oreq_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got cnt=%0d valid=%b want 0 0", dut.starve_cnt, oreq_valid);
        end
        clear_inputs();
        resetn = 1;
        advance();
    endtask

    task automatic test_single_i();
        i_req_valid = 1;
        i_req_addr = 32'hBFC0_0000;
        #1;
        total++;
        if (oreq_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_c0_idle: got oreq_valid=%b want 0", oreq_valid);
        end
        advance();
        #1;
        total++;
        if (oreq_addr !== 32'hBFC0_0000 || oreq_valid !== 1'b1 || i_resp_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_c1_grant: got addr=%h valid=%b irdy=%b want bfc00000 1 0", oreq_addr, oreq_valid, i_resp_ready);
        end
        advance();
        {oresp_ready, oresp_last} = 2'b11;
        oresp_data = 32'h1234_5678;
        #1;
        total++;
        if ({i_resp_ready, i_resp_last, d_resp_ready, d_resp_last} !== 4'b1100 || i_resp_data !== 32'h1234_5678 || d_resp_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL single_c2_resp: got rdy/last=%b%b%b%b data=%h/%h want 1100 12345678",
                     i_resp_ready, i_resp_last, d_resp_ready, d_resp_last, i_resp_data, d_resp_data);
        end
        advance();
        {oresp_ready, oresp_last} = 2'b00;
        #1;
        total++;
        if (oreq_valid !== 1'b0 || oreq_addr !== 32'd0) begin
            bad++;
            $display("FAIL single_c3_idle_gap: got valid=%b addr=%h want 0 0", oreq_valid, oreq_addr);
        end
        i_req_valid = 0;
        advance();
    endtask

    task automatic test_both();
        i_req_valid = 1;
        i_req_addr = IA;
        d_req_valid = 1;
        d_req_addr = DA;
        d_req_is_write = 1;
        d_req_strobe = 4'hF;
        d_req_data = 32'hCAFE_F00D;
        advance();
        #1;
        total++;
        if (oreq_addr !== DA || oreq_is_write !== 1'b1 || oreq_strobe !== 4'hF || oreq_data !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL both_d_grant: got addr=%h wr=%b strb=%h data=%h want %h 1 f cafef00d",
                     oreq_addr, oreq_is_write, oreq_strobe, oreq_data, DA);
        end
        {oresp_ready, oresp_last} = 2'b11;
        #1;
        total++;
        if (i_resp_ready !== 1'b0 || d_resp_ready !== 1'b1) begin
            bad++;
            $display("FAIL both_resp_route: got irdy=%b drdy=%b want 0 1", i_resp_ready, d_resp_ready);
        end
        advance();
        {oresp_ready, oresp_last} = 2'b00;
        d_req_valid = 0;
        advance();
        #1;
        total++;
        if (oreq_addr !== IA || oreq_valid !== 1'b1) begin
            bad++;
            $display("FAIL both_i_after: got addr=%h valid=%b want %h 1", oreq_addr, oreq_valid, IA);
        end
        {oresp_ready, oresp_last} = 2'b11;
        advance();
        clear_inputs();
        advance();
    endtask

    task automatic test_starve();
        logic [31:0] want;
        i_req_valid = 1;
        i_req_addr = IA;
        d_req_valid = 1;
        d_req_addr = DA;
        for (int g = 0; g < 5; g++) begin
            {oresp_ready, oresp_last} = 2'b00;
            advance();
            {oresp_ready, oresp_last} = 2'b11;
            want = g < L ? DA : IA;
            #1;
            total++;
            if (oreq_addr !== want) begin
                bad++;
                $display("FAIL starve_grant_%0d: got addr=%h want %h", g, oreq_addr, want);
            end
            advance();
        end
        #1;
        total++;
        if (dut.starve_cnt !== 3'd0) begin
            bad++;
            $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt);
        end
        clear_inputs();
        advance();
    endtask

    task automatic test_burst();
        i_req_valid = 1;
        i_req_addr = IA;
        i_req_len = 4'd3;
        advance();
        d_req_valid = 1;
        d_req_addr = DA;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                i_req_valid = 0;
                #1;
                total++;
                if (oreq_valid !== 1'b0 || oreq_addr !== IA) begin
                    bad++;
                    $display("FAIL burst_valid_drop: got valid=%b addr=%h want 0 %h", oreq_valid, oreq_addr, IA);
                end
                advance();
                i_req_valid = 1;
            end
            {oresp_ready, oresp_last} = {1'b1, b == 3};
            #1;
            total++;
            if ({i_resp_ready, d_resp_ready, oreq_valid, oreq_len} !== {3'b101, 4'd3}) begin
                bad++;
                $display("FAIL burst_beat_%0d: got irdy=%b drdy=%b valid=%b len=%0d want 1 0 1 3",
                         b, i_resp_ready, d_resp_ready, oreq_valid, oreq_len);
            end
            advance();
        end
        clear_inputs();
        #1;
        total++;
        if (oreq_valid !== 1'b0 || i_resp_ready !== 1'b0) begin
            bad++;
            $display("FAIL burst_end_idle: got valid=%b irdy=%b want 0 0", oreq_valid, i_resp_ready);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        i_req_valid = 1;
        i_req_addr = IA;
        i_req_len = 4'd3;
        advance();
        oresp_ready = 1;
        advance();
        #1;
        total++;
        if (i_resp_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_beat2: got irdy=%b want 1", i_resp_ready);
        end
        #1 resetn = 0;
        owner = 0;
        waits = 0;
        #1;
        total++;
        if (oreq_valid !== 1'b0 || i_resp_ready !== 1'b0 || d_resp_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: got valid=%b irdy=%b drdy=%b want 0 0 0", oreq_valid, i_resp_ready, d_resp_ready);
        end
        advance();
        resetn = 1;
        i_req_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (i_resp_ready !== 1'b0 || oreq_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_after_%0d: got irdy=%b valid=%b want 0 0", c, i_resp_ready, oreq_valid);
            end
            advance();
        end
        oresp_ready = 0;
        i_req_valid = 1;
        advance();
        #1;
        total++;
        if (oreq_valid !== 1'b1 || oreq_addr !== IA) begin
            bad++;
            $display("FAIL rstmid_first_arb: got valid=%b addr=%h want 1 %h", oreq_valid, oreq_addr, IA);
        end
        {oresp_ready, oresp_last} = 2'b11;
        advance();
        clear_inputs();
        advance();
    endtask

    task automatic test_idle_ready();
        {oresp_ready, oresp_last} = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({i_resp_ready, i_resp_last, d_resp_ready, d_resp_last, oreq_valid} !== 5'd0) begin
                bad++;
                $display("FAIL idle_ready_%0d: got rdy=%b%b last=%b%b valid=%b want 0",
                         c, i_resp_ready, d_resp_ready, i_resp_last, d_resp_last, oreq_valid);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            {i_req_is_write, i_req_size, i_req_strobe, i_req_len} = 12'($urandom);
            {d_req_is_write, d_req_size, d_req_strobe, d_req_len} = 12'($urandom);
            i_req_addr = $urandom;
            i_req_data = $urandom;
            d_req_addr = $urandom;
            d_req_data = $urandom;
            oresp_data = $urandom;
            i_req_valid = $urandom_range(0, 3) != 0;
            d_req_valid = $urandom_range(0, 3) != 0;
            oresp_ready = $urandom_range(0, 1);
            oresp_last = $urandom_range(0, 2) == 0;
            #1;
            total++;
            if ({oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len} !== exp_oreq() ||
                {i_resp_ready, i_resp_last, d_resp_ready, d_resp_last} !== exp_resp() ||
                i_resp_data !== oresp_data || d_resp_data !== oresp_data || dut.starve_cnt !== 3'(waits)) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL random_c%0d: got valid=%b addr=%h rdy=%b%b last=%b%b cnt=%0d want owner=%0d oreq=%h resp=%b cnt=%0d",
                             c, oreq_valid, oreq_addr, i_resp_ready, d_resp_ready, i_resp_last, d_resp_last,
                             dut.starve_cnt, owner, exp_oreq(), exp_resp(), waits);
            end
            advance();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_i();
        test_both();
        test_starve();
        test_burst();
        test_reset_mid();
        test_idle_ready();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants after which a waiting instruction request wins.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have, for each of the prefixes i_ (instruction) and d_ (data), inputs req_valid 1, req_is_write 1, req_size 3, req_addr 32, req_strobe 4, req_data 32 and req_len 4 (beats-1).
REQ-005 SHALL have, for each of the prefixes i_ and d_, outputs resp_ready 1, resp_last 1 and resp_data 32.
REQ-006 SHALL have outputs oreq_valid 1, oreq_is_write 1, oreq_size 3, oreq_addr 32, oreq_strobe 4, oreq_data 32 and oreq_len 4, toward the bus converter.
REQ-007 SHALL have inputs oresp_ready 1, oresp_last 1 and oresp_data 32, from the bus converter.

Function
REQ-008 SHALL implement a state machine with states IDLE, BUSY_I and BUSY_D.
REQ-009 In IDLE, oreq_valid SHALL be 0 and all other oreq_* outputs SHALL be 0.
REQ-010 In IDLE, if only one req_valid is high, the state SHALL move to that port's BUSY state at the next edge.
REQ-011 In IDLE with both req_valid high, BUSY_D SHALL be chosen unless starve_cnt == STARVE_LIMIT, in which case BUSY_I SHALL be chosen.
REQ-012 Arbitration latency SHALL be exactly one cycle: a request first seen in IDLE at cycle N SHALL appear on oreq at cycle N+1.
REQ-013 In BUSY_x, all oreq_* outputs SHALL be combinational pass-throughs of port x's req_* fields, and the block SHALL NOT latch any of them.
REQ-014 In BUSY_x, x_resp_ready SHALL equal oresp_ready and x_resp_last SHALL equal oresp_last; the other port's resp_ready and resp_last SHALL be 0.
REQ-015 oresp_data SHALL be broadcast to both resp_data outputs at all times.
REQ-016 In BUSY_x, the cycle with oresp_ready && oresp_last SHALL end the transaction, and the state SHALL be IDLE at the next edge.
REQ-017 There SHALL be no back-to-back grant: at least one IDLE cycle SHALL separate consecutive transactions.
REQ-018 Multi-beat bursts (len>0) SHALL remain in BUSY_x across all beats; only a beat with last ends the transaction.
REQ-019 If the granted port drops req_valid before its last beat, the state SHALL stay BUSY_x and oreq_valid SHALL follow req_valid.
REQ-020 If oresp_ready is asserted in IDLE, it SHALL be ignored and both resp_ready outputs SHALL remain 0.
REQ-021 starve_cnt SHALL be a counter of width clog2(STARVE_LIMIT+1).
REQ-022 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each IDLE->BUSY_D transition taken while i_req_valid is high.
REQ-023 starve_cnt SHALL clear on every IDLE->BUSY_I transition.
REQ-024 starve_cnt SHALL hold its value on a BUSY_D grant made while i_req_valid is low.

Reset
REQ-025 On resetn low, the state SHALL go to IDLE and starve_cnt SHALL go to 0 asynchronously, independent of clk.
REQ-026 During reset, oreq_valid, all oreq_* outputs, and both resp_ready and resp_last outputs SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abandon the transaction without any further resp_ready pulse.
REQ-028 After reset deassertion, the first arbitration SHALL occur in the first IDLE cycle with a req_valid high.

Verification
REQ-029 Test: i_req_valid alone, read addr 0xBFC00000, len 0, and oresp ready+last at cycle 2 -> oreq_addr=0xBFC00000 at cycle 1, i_resp_ready=1 at cycle 2, IDLE at cycle 3.
REQ-030 Test: both ports valid with starve_cnt 0 -> BUSY_D granted, d_ write strobe 0xF passes through, i_resp_ready held 0, BUSY_I granted after the data last.
REQ-031 Test: data continuously valid with an instruction waiting, STARVE_LIMIT=4 -> four D grants, then an I grant, then starve_cnt reads 0.
REQ-032 Test: instruction burst len=3 with oresp_last only on beat 4 -> four i_resp_ready pulses, the state remains BUSY_I throughout, d_resp_ready stays 0.
REQ-033 Test: resetn pulsed low between clock edges during beat 2 of a burst -> oreq_valid=0 immediately, state IDLE, no further resp_ready.
REQ-034 Test: oresp_ready asserted in IDLE with no requests -> i_resp_ready=d_resp_ready=0 and the state remains IDLE.
